// File: rtl/rr_mux_scheduler_if.sv
// ----------------------------------------------------------------------------
// rr_mux_scheduler_if
//   Bundles the request side and the output side of the round-robin mux
//   scheduler.
//
//   Signals:
//     req[3:0]        per-channel request, bit i = channel i has a word
//     a, b, c, d      channel 0..3 data words (4 bits each)
//     out_ready       downstream accepts out_data this cycle
//     sel[1:0]        index of the channel last loaded (mux select)
//     grant[3:0]      one-hot, one-cycle acknowledge to the loaded channel
//     out_data[3:0]   registered word of the selected channel
//     out_valid       out_data holds an unconsumed word
//     xfer_count      completed output handshakes, modulo 2^CNT_W
//
//   Handshake: a word moves downstream on every rising edge where
//   out_valid && out_ready. out_valid, out_data and sel stay stable while
//   out_valid && !out_ready. Requesters hold req/data until they see their
//   grant bit.
//
//   Modports:
//     slave  - the scheduler (consumes requests, produces output)
//     master - the environment (requesters and downstream consumer)
// ----------------------------------------------------------------------------
interface rr_mux_scheduler_if #(
    parameter int CNT_W = 8
);
    logic [3:0]       req;
    logic [3:0]       a;
    logic [3:0]       b;
    logic [3:0]       c;
    logic [3:0]       d;
    logic             out_ready;
    logic [1:0]       sel;
    logic [3:0]       grant;
    logic [3:0]       out_data;
    logic             out_valid;
    logic [CNT_W-1:0] xfer_count;

    modport slave (
        input  req, a, b, c, d, out_ready,
        output sel, grant, out_data, out_valid, xfer_count
    );

    modport master (
        output req, a, b, c, d, out_ready,
        input  sel, grant, out_data, out_valid, xfer_count
    );
endinterface

// File: rtl/rr_mux_scheduler.sv
// ----------------------------------------------------------------------------
// rr_mux_scheduler
//   Round-robin scheduler for a 4-channel, 4-bit mux stage. Picks one of four
//   requesting channels, registers its word in a one-entry output buffer
//   under a valid/ready handshake, drives the mux select, and counts
//   completed output transfers.
//
//   Ports:
//     clk          rising-edge clock
//     rst          synchronous reset, active-high
//     sched        rr_mux_scheduler_if.slave (requests, data, output handshake)
//     o_dbg_state  current FSM state (0 = EMPTY, 1 = FULL)
//     o_dbg_ptr    round-robin pointer (first channel searched next)
//
//   All outputs are registered; there is no combinational path from req to
//   any output.
// ----------------------------------------------------------------------------
module rr_mux_scheduler #(
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    rr_mux_scheduler_if.slave      sched,
    output logic                   o_dbg_state,
    output logic [1:0]             o_dbg_ptr
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_ptr;
    logic [1:0]       r_sel;
    logic [3:0]       r_grant;
    logic [3:0]       r_data;
    logic [CNT_W-1:0] r_count;

    logic [3:0]       w_ereq;
    logic             w_found;
    logic [1:0]       w_win;
    logic [3:0]       w_win_data;
    logic             w_load;
    logic             w_hs;

    // The channel granted last cycle may still show its old request; masking
    // it keeps the same word from being loaded twice.
    assign w_ereq = sched.req & ~r_grant;

    // Search ptr, ptr+1, ptr+2, ptr+3; the 2-bit add wraps mod 4.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        for (int i = 0; i < 4; i++) begin
            if (!w_found && w_ereq[r_ptr + 2'(i)]) begin
                w_found = 1'b1;
                w_win   = r_ptr + 2'(i);
            end
        end
    end

    always_comb begin
        w_win_data = sched.a;
        case (w_win)
            2'd0:    w_win_data = sched.a;
            2'd1:    w_win_data = sched.b;
            2'd2:    w_win_data = sched.c;
            default: w_win_data = sched.d;
        endcase
    end

    assign w_hs   = (r_state == FULL) && sched.out_ready;
    assign w_load = w_found && ((r_state == EMPTY) || sched.out_ready);

    // Next state: a load always leaves the buffer FULL (including
    // back-to-back handshake+load); a handshake with no load drains it.
    always_comb begin
        w_state_nxt = r_state;
        if (w_load) begin
            w_state_nxt = FULL;
        end else if (w_hs) begin
            w_state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= 2'd0;
            r_sel   <= 2'd0;
            r_grant <= 4'd0;
            r_data  <= 4'd0;
            r_count <= '0;
        end else begin
            // grant is a one-cycle pulse following a load only.
            r_grant <= 4'd0;
            if (w_load) begin
                r_data  <= w_win_data;
                r_sel   <= w_win;
                r_grant <= 4'b0001 << w_win;
                r_ptr   <= w_win + 2'd1;
            end
            if (w_hs) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign sched.sel        = r_sel;
    assign sched.grant      = r_grant;
    assign sched.out_data   = r_data;
    assign sched.out_valid  = (r_state == FULL);
    assign sched.xfer_count = r_count;

    assign o_dbg_state = r_state;
    assign o_dbg_ptr   = r_ptr;

endmodule

// File: tb/tb_rr_mux_scheduler.sv
// ----------------------------------------------------------------------------
// tb_rr_mux_scheduler
//   Directed bench for rr_mux_scheduler. Inputs change 1 time unit after a
//   rising edge and outputs are checked at the same point, so every check
//   sees the result of the edge just taken.
// ----------------------------------------------------------------------------
module tb_rr_mux_scheduler;

    localparam int CNT_W = 8;

    logic       clk;
    logic       rst;
    logic       dbg_state;
    logic [1:0] dbg_ptr;

    int n_vec;
    int n_err;

    rr_mux_scheduler_if #(.CNT_W(CNT_W)) bus ();

    rr_mux_scheduler #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .sched       (bus.slave),
        .o_dbg_state (dbg_state),
        .o_dbg_ptr   (dbg_ptr)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = 4'h0;
        bus.out_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic set_data(input logic [3:0] va, input logic [3:0] vb,
                            input logic [3:0] vc, input logic [3:0] vd);
        bus.a = va;
        bus.b = vb;
        bus.c = vc;
        bus.d = vd;
    endtask

    // ---------------- tests ----------------
    // Observed vector packing used below: {out_valid, sel, out_data, grant}.
    task automatic test_reset();
        rst = 1'b1;
        bus.req = 4'hF;
        bus.out_ready = 1'b1;
        set_data(4'h1, 4'h2, 4'h3, 4'h4);
        step();
        step();
        n_vec++;
        if ({bus.out_valid, bus.sel, bus.out_data, bus.grant} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h required 000",
                     {bus.out_valid, bus.sel, bus.out_data, bus.grant});
        end
        n_vec++;
        if ({bus.xfer_count, dbg_ptr} !== {8'd0, 2'd0}) begin
            n_err++;
            $display("FAIL reset_count_ptr: got count=%0d ptr=%0d required 0 0",
                     bus.xfer_count, dbg_ptr);
        end
        rst = 1'b0;
        step();
        n_vec++;
        if ({bus.out_valid, bus.sel, bus.out_data, bus.grant} !== {1'b1, 2'd0, 4'h1, 4'b0001}) begin
            n_err++;
            $display("FAIL reset_first_load: got v=%b sel=%0d data=%h grant=%b required v=1 sel=0 data=1 grant=0001",
                     bus.out_valid, bus.sel, bus.out_data, bus.grant);
        end
    endtask

    task automatic test_single();
        do_reset();
        set_data(4'h0, 4'h0, 4'hA, 4'h0);
        bus.req = 4'b0100;
        bus.out_ready = 1'b1;
        step();
        n_vec++;
        if ({bus.out_valid, bus.sel, bus.out_data, bus.grant} !== {1'b1, 2'd2, 4'hA, 4'b0100}) begin
            n_err++;
            $display("FAIL single_load: got v=%b sel=%0d data=%h grant=%b required v=1 sel=2 data=a grant=0100",
                     bus.out_valid, bus.sel, bus.out_data, bus.grant);
        end
        bus.req = 4'b0000;
        step();
        n_vec++;
        if ({bus.out_valid, bus.grant, bus.xfer_count, dbg_ptr} !== {1'b0, 4'b0000, 8'd1, 2'd3}) begin
            n_err++;
            $display("FAIL single_drain: got v=%b grant=%b count=%0d ptr=%0d required v=0 grant=0000 count=1 ptr=3",
                     bus.out_valid, bus.grant, bus.xfer_count, dbg_ptr);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_data [6] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1, 4'h2};
        logic [1:0] exp_sel  [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        logic [3:0] exp_gnt  [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        do_reset();
        set_data(4'h1, 4'h2, 4'h3, 4'h4);
        bus.req = 4'hF;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            n_vec++;
            if ({bus.out_valid, bus.sel, bus.out_data, bus.grant} !==
                {1'b1, exp_sel[i], exp_data[i], exp_gnt[i]}) begin
                n_err++;
                $display("FAIL rr_cycle%0d: got v=%b sel=%0d data=%h grant=%b required v=1 sel=%0d data=%h grant=%b",
                         i, bus.out_valid, bus.sel, bus.out_data, bus.grant,
                         exp_sel[i], exp_data[i], exp_gnt[i]);
            end
        end
        n_vec++;
        if (bus.xfer_count !== 8'd5) begin
            n_err++;
            $display("FAIL rr_count: got %0d required 5", bus.xfer_count);
        end
        bus.req = 4'h0;
    endtask

    task automatic test_backpressure();
        do_reset();
        set_data(4'h1, 4'h5, 4'h3, 4'h4);
        bus.req = 4'b0010;
        bus.out_ready = 1'b0;
        step();
        n_vec++;
        if ({bus.out_valid, bus.sel, bus.out_data, bus.grant, dbg_ptr} !==
            {1'b1, 2'd1, 4'h5, 4'b0010, 2'd2}) begin
            n_err++;
            $display("FAIL bp_load: got v=%b sel=%0d data=%h grant=%b ptr=%0d required v=1 sel=1 data=5 grant=0010 ptr=2",
                     bus.out_valid, bus.sel, bus.out_data, bus.grant, dbg_ptr);
        end
        bus.req = 4'hF;
        for (int i = 0; i < 5; i++) begin
            step();
            n_vec++;
            if ({bus.out_valid, bus.sel, bus.out_data, bus.grant, dbg_ptr} !==
                {1'b1, 2'd1, 4'h5, 4'b0000, 2'd2}) begin
                n_err++;
                $display("FAIL bp_stall%0d: got v=%b sel=%0d data=%h grant=%b ptr=%0d required v=1 sel=1 data=5 grant=0000 ptr=2",
                         i, bus.out_valid, bus.sel, bus.out_data, bus.grant, dbg_ptr);
            end
        end
        bus.out_ready = 1'b1;
        step();
        n_vec++;
        if ({bus.out_valid, bus.sel, bus.out_data, bus.grant, bus.xfer_count} !==
            {1'b1, 2'd2, 4'h3, 4'b0100, 8'd1}) begin
            n_err++;
            $display("FAIL bp_release: got v=%b sel=%0d data=%h grant=%b count=%0d required v=1 sel=2 data=3 grant=0100 count=1",
                     bus.out_valid, bus.sel, bus.out_data, bus.grant, bus.xfer_count);
        end
        bus.req = 4'h0;
    endtask

    task automatic test_grant_mask();
        do_reset();
        set_data(4'h0, 4'h0, 4'h0, 4'h7);
        bus.req = 4'b1000;
        bus.out_ready = 1'b1;
        step();
        n_vec++;
        if ({bus.out_valid, bus.sel, bus.out_data, bus.grant} !== {1'b1, 2'd3, 4'h7, 4'b1000}) begin
            n_err++;
            $display("FAIL mask_load: got v=%b sel=%0d data=%h grant=%b required v=1 sel=3 data=7 grant=1000",
                     bus.out_valid, bus.sel, bus.out_data, bus.grant);
        end
        // req[3] still high one cycle after its grant: must not reload.
        step();
        n_vec++;
        if ({bus.out_valid, bus.grant, bus.xfer_count} !== {1'b0, 4'b0000, 8'd1}) begin
            n_err++;
            $display("FAIL mask_no_reload: got v=%b grant=%b count=%0d required v=0 grant=0000 count=1",
                     bus.out_valid, bus.grant, bus.xfer_count);
        end
        bus.req = 4'h0;
    endtask

    task automatic test_counter_wrap();
        do_reset();
        set_data(4'h1, 4'h2, 4'h3, 4'h4);
        bus.req = 4'hF;
        bus.out_ready = 1'b1;
        // Edge n leaves xfer_count = n-1 (first edge only loads).
        for (int n = 1; n <= 258; n++) begin
            step();
            if (n == 256) begin
                n_vec++;
                if (bus.xfer_count !== 8'd255) begin
                    n_err++;
                    $display("FAIL wrap_255: got %0d required 255", bus.xfer_count);
                end
            end
            if (n == 257) begin
                n_vec++;
                if (bus.xfer_count !== 8'd0) begin
                    n_err++;
                    $display("FAIL wrap_0: got %0d required 0", bus.xfer_count);
                end
            end
        end
        n_vec++;
        if ({bus.out_valid, bus.xfer_count} !== {1'b1, 8'd1}) begin
            n_err++;
            $display("FAIL wrap_257: got v=%b count=%0d required v=1 count=1",
                     bus.out_valid, bus.xfer_count);
        end
        // Reset while FULL with a handshake pending: word dropped, not counted.
        rst = 1'b1;
        step();
        n_vec++;
        if ({bus.out_valid, bus.xfer_count, bus.grant} !== {1'b0, 8'd0, 4'b0000}) begin
            n_err++;
            $display("FAIL reset_full: got v=%b count=%0d grant=%b required v=0 count=0 grant=0000",
                     bus.out_valid, bus.xfer_count, bus.grant);
        end
        rst = 1'b0;
        bus.req = 4'h0;
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.req = 4'h0;
        bus.out_ready = 1'b0;
        set_data(4'h0, 4'h0, 4'h0, 4'h0);

        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_grant_mask();
        test_counter_wrap();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
